button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 131 +++++++++++++
 tb/tb_button_event_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin arbiter queuing one-shot button presses into an event FIFO
// Optional saturating lost-press counter: define BTN_ARB_DROP_CNT_EN.
module button_event_arbiter #(
  parameter int NUM_BTN    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_pulse,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic [NUM_BTN-1:0]         pending,
  output logic [7:0]                 drop_cnt,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_BTN);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [IDW-1:0]     mem_q [FIFO_DEPTH];

  logic               full;
  logic               push;
  logic               pop;
  logic [NUM_BTN-1:0] grant_oh;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     cand;

  assign full      = (count_q == DEPTH_C);
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign evt_id    = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign pending   = pending_q;
  assign busy      = (|pending_q) | evt_valid;

  // Round-robin search over pending buttons, starting one past the previous winner
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    push      = 1'b0;
    cand      = '0;
    if ((|pending_q) && !full) begin
      for (int k = 1; k <= NUM_BTN; k++) begin
        cand = IDW'((int'(last_grant_q) + k) % NUM_BTN);
        if (!push && pending_q[cand]) begin
          push           = 1'b1;
          grant_idx      = cand;
          grant_oh[cand] = 1'b1;
        end
      end
    end
  end

  // Next-state: a fresh press on the granted button re-arms its pending bit
  always_comb begin
    pending_d    = (pending_q & ~grant_oh) | btn_pulse;
    last_grant_d = push ? grant_idx : last_grant_q;
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Arbiter and queue bookkeeping; last_grant resets so that index 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      last_grant_q <= IDW'(NUM_BTN - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Queue storage; contents are only visible through evt_id while occupancy is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= grant_idx;
    end
  end

`ifdef BTN_ARB_DROP_CNT_EN
  logic [NUM_BTN-1:0] drop_vec;
  logic [3:0]         drop_num;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  // A press landing on a still-pending, ungranted button is lost; tally them with saturation
  always_comb begin
    drop_vec = btn_pulse & pending_q & ~grant_oh;
    drop_num = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      drop_num = drop_num + {3'd0, drop_vec[i]};
    end
    drop_sum   = {1'b0, drop_cnt_q} + {5'd0, drop_num};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Lost-press counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed scoreboard bench for button_event_arbiter
module tb_button_event_arbiter;

  localparam int NUM_BTN    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef BTN_ARB_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   btn_pulse;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic [3:0]   pending;
  logic [7:0]   drop_cnt;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  button_event_arbiter #(
    .NUM_BTN   (NUM_BTN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_pulse(btn_pulse),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .pending  (pending),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic int exp_drop(input int n);
    return DROP_EN ? n : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: score any pop that the coming edge performs, then clear the pulses
  task automatic tick();
    if (!reset && evt_valid && evt_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL spurious_evt observed id=%0d expected=none", evt_id);
      end
      if (exp_q.size() > 0) check("evt_order", evt_id, exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    btn_pulse = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn_pulse = '0;
    evt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("drain_sb_empty", exp_q.size(), 0);
    evt_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_pulse = '0;
    evt_ready = 1'b0;
    @(negedge clk);

    // reset state, inputs ignored while reset is held
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_pending", pending, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_busy", busy, 0);
    btn_pulse = 4'hF;
    evt_ready = 1'b1;
    tick();
    check("rst_ign_pending", pending, 0);
    check("rst_ign_valid", evt_valid, 0);
    evt_ready = 1'b0;
    reset     = 1'b0;
    tick();
    tick();
    check("idle_valid", evt_valid, 0);

    // single press latency: pending at edge k, event after k+1, popped at k+2
    evt_ready = 1'b1;
    btn_pulse = 4'b0100;
    exp_q.push_back(2);
    tick();
    check("lat_pending_k", pending, 4'b0100);
    check("lat_valid_k", evt_valid, 0);
    check("lat_busy_k", busy, 1);
    tick();
    check("lat_valid_k1", evt_valid, 1);
    check("lat_id_k1", evt_id, 2);
    check("lat_pending_k1", pending, 0);
    tick();
    check("lat_valid_k2", evt_valid, 0);
    check("lat_id_idle", evt_id, 0);
    check("lat_busy_k2", busy, 0);
    check("lat_sb_empty", exp_q.size(), 0);

    // simultaneous presses 0,1,3 queued in round-robin order from index 0
    do_reset();
    btn_pulse = 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    tick();
    check("rr_pending0", pending, 4'b1011);
    check("rr_valid0", evt_valid, 0);
    tick();
    check("rr_pending1", pending, 4'b1010);
    check("rr_id1", evt_id, 0);
    tick();
    check("rr_pending2", pending, 4'b1000);
    tick();
    check("rr_pending3", pending, 4'b0000);
    check("rr_busy3", busy, 1);
    tick();
    check("rr_pending4", pending, 4'b0000);
    drain();
    check("rr_valid_end", evt_valid, 0);
    check("rr_busy_end", busy, 0);

    // fill the queue, hold a pending press while full, drop a repeated press
    do_reset();
    btn_pulse = 4'b0001; exp_q.push_back(0); tick();
    btn_pulse = 4'b0010; exp_q.push_back(1); tick();
    btn_pulse = 4'b0100; exp_q.push_back(2); tick();
    btn_pulse = 4'b1000; exp_q.push_back(3); tick();
    btn_pulse = 4'b0001; exp_q.push_back(0); tick();
    tick();
    check("full_pending", pending, 4'b0001);
    check("full_valid", evt_valid, 1);
    check("full_id", evt_id, 0);
    tick();
    check("full_hold_pending", pending, 4'b0001);
    btn_pulse = 4'b0010; exp_q.push_back(1); tick();
    check("full_b1_pending", pending, 4'b0011);
    check("full_b1_nodrop", drop_cnt, 0);
    btn_pulse = 4'b0010; tick();
    check("full_b1_drop", drop_cnt, exp_drop(1));
    check("full_b1_pending2", pending, 4'b0011);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("full_pop_no_grant", pending, 4'b0011);
    tick();
    check("full_regrant", pending, 4'b0010);
    check("full_regrant_valid", evt_valid, 1);
    drain();
    check("full_valid_end", evt_valid, 0);
    check("full_pending_end", pending, 0);
    check("full_drop_end", drop_cnt, exp_drop(1));

    // multi-drop per cycle and saturation at 255
    do_reset();
    btn_pulse = 4'hF;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("sat_pending_0", pending, 0);
    check("sat_busy", busy, 1);
    btn_pulse = 4'hF; tick();
    check("sat_first_no_drop", drop_cnt, 0);
    check("sat_pending_f", pending, 4'hF);
    btn_pulse = 4'hF; tick();
    check("sat_multi_drop", drop_cnt, exp_drop(4));
    for (int i = 0; i < 60; i++) begin
      btn_pulse = 4'hF;
      tick();
    end
    check("sat_244", drop_cnt, exp_drop(244));
    for (int i = 0; i < 10; i++) begin
      btn_pulse = 4'hF;
      tick();
    end
    check("sat_255", drop_cnt, exp_drop(255));
    for (int i = 0; i < 10; i++) begin
      btn_pulse = 4'hF;
      tick();
    end
    check("sat_255_held", drop_cnt, exp_drop(255));
    check("sat_head", evt_id, 0);

    // reset mid-operation with three queued and two pending discards everything
    do_reset();
    btn_pulse = 4'b0111; exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); tick();
    tick();
    tick();
    btn_pulse = 4'b1001; tick();
    check("mid_pending", pending, 4'b1001);
    check("mid_valid", evt_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_id", evt_id, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    reset     = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_valid", evt_valid, 0);
    check("post_rst_pending", pending, 0);
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
